// File: rtl/serial_frame_arbiter.sv
// ---------------------------------------------------------------------------
// serial_frame_arbiter
//
// Shares one shift-in deserializer among n_req serial requesters. A
// requester is granted for one whole frame of exactly `width` bits. Its bits
// are assembled LSB-first, so the first accepted bit lands in out_data[0].
// The assembled frame is then offered downstream with its source index.
// Arbitration is round-robin, starting one past the last requester served.
//
// Ports
//   clk        : single clock; all state changes on its rising edge
//   rst        : asynchronous active-low reset, released synchronously
//   req_valid  : [n_req] per-requester serial bit valid
//   req_data   : [n_req] per-requester serial data bit
//   req_ready  : [n_req] per-requester bit accept (only the granted bit, only
//                while collecting)
//   out_valid  : assembled frame available
//   out_data   : [width] assembled frame
//   out_id     : [$clog2(n_req)] requester that sourced out_data
//   out_ready  : downstream accept
// ---------------------------------------------------------------------------
module serial_frame_arbiter #(
  parameter int n_req = 4,
  parameter int width = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [n_req-1:0]         req_valid,
  input  logic [n_req-1:0]         req_data,
  output logic [n_req-1:0]         req_ready,
  output logic                     out_valid,
  output logic [width-1:0]         out_data,
  output logic [$clog2(n_req)-1:0] out_id,
  input  logic                     out_ready
);

  localparam int ID_W  = $clog2(n_req);
  localparam int CNT_W = $clog2(width + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] OUTPUT  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(width - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(width);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(n_req - 1);

  logic [1:0]       state;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  rr_winner;
  logic [ID_W-1:0]  rr_idx;
  logic             rr_found;
  logic [CNT_W-1:0] bit_cnt;
  logic             granted_valid;
  logic             granted_bit;

  // Round-robin search: try last_grant+1, last_grant+2, ... wrapping, and
  // take the first requester with a valid bit. Only used in IDLE.
  always_comb begin
    rr_winner = last_grant;
    rr_idx    = '0;
    rr_found  = 1'b0;
    for (int k = 1; k <= n_req; k++) begin
      rr_idx = ID_W'((int'(last_grant) + k) % n_req);
      if (!rr_found && req_valid[rr_idx]) begin
        rr_found  = 1'b1;
        rr_winner = rr_idx;
      end
    end
  end

  assign granted_valid = req_valid[grant];
  assign granted_bit   = req_data[grant];

  // Only the granted requester sees ready, and only while bits are being
  // gathered; everyone else is ignored, so frames can never mix sources.
  always_comb begin
    req_ready = '0;
    if (state == COLLECT) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign out_valid = (state == OUTPUT);
  assign out_id    = grant;

  // Main control. A requester dropping valid mid-frame only creates a gap;
  // the grant is released solely by the output handshake or by reset.
  // Bits shift in from the top, so after exactly width bits the first one
  // has moved down to out_data[0].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LAST_ID;
      bit_cnt    <= '0;
      out_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant   <= rr_winner;
            bit_cnt <= '0;
            state   <= COLLECT;
          end
        end
        COLLECT: begin
          if (granted_valid) begin
            out_data <= {granted_bit, out_data[width-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= FULL_CNT;
              state   <= OUTPUT;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_arbiter
//
// Self-checking bench for serial_frame_arbiter (n_req=4, width=8).
// Directed table, hand-written corner sequences and a randomized run. The
// random run is checked against a transaction-level reference model that
// tracks the current owner, a queue of collected bits and a pending frame.
// ---------------------------------------------------------------------------
module tb_serial_frame_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_data;
  logic [N-1:0] req_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_id;
  logic         out_ready;

  int compared   = 0;
  int mismatched = 0;

  serial_frame_arbiter #(.n_req(N), .width(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the deserializer (-1 = nobody), the bits
  // collected so far, and a finished frame waiting for downstream.
  int           m_owner;
  int           m_last;
  bit           m_bits[$];
  bit           m_have;
  logic [W-1:0] m_frame;
  int           m_id;

  function automatic void model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_bits.delete();
    m_have  = 1'b0;
    m_frame = '0;
    m_id    = 0;
  endfunction

  function automatic void model_step(input logic [N-1:0] v, input logic [N-1:0] d,
                                     input logic r);
    if (m_have) begin
      if (r) begin
        m_last  = m_id;
        m_have  = 1'b0;
        m_owner = -1;
      end
    end else if (m_owner < 0) begin
      if (v != '0) begin
        for (int k = 1; k <= N; k++) begin
          int c = (m_last + k) % N;
          if (v[c]) begin
            m_owner = c;
            break;
          end
        end
        m_bits.delete();
      end
    end else if (v[m_owner]) begin
      m_bits.push_back(d[m_owner]);
      if (m_bits.size() == W) begin
        for (int b = 0; b < W; b++) m_frame[b] = m_bits[b];
        m_have = 1'b1;
        m_id   = m_owner;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs just after an edge, compare the DUT with
  // the model's view of the current cycle, then advance both.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] d,
                               input logic r);
    logic [N-1:0] er;
    req_valid = v;
    req_data  = d;
    out_ready = r;
    er = '0;
    if (m_owner >= 0 && !m_have) er[m_owner] = 1'b1;
    checkOutput("req_ready", req_ready, er);
    checkOutput("out_valid", out_valid, m_have);
    if (m_have) begin
      checkOutput("out_data", out_data, m_frame);
      checkOutput("out_id", out_id, m_id);
    end
    model_step(v, d, r);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_id", out_id, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] d;
    logic         r;
    logic [N-1:0] er;
    logic         ev;
    logic [W-1:0] ed;
    logic [1:0]   eid;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [W-1:0] pat;
    logic [W-1:0] bits30;
    int           ids[5];
    int           at[5];
    int           nf;
    int           exp_ids[5];

    // Single-source frame from requester 2: bits 1,0,1,1,0,0,1,0 -> 8'h4D.
    bits30 = 8'h4D;
    tbl[0] = '{v: 4'b0100, d: 4'b0000, r: 1'b1, er: 4'b0000, ev: 1'b0, ed: 8'h00, eid: 2'd0};
    for (int i = 1; i <= 8; i++) begin
      tbl[i] = '{v: 4'b0100, d: {1'b0, bits30[i-1], 2'b00}, r: 1'b1, er: 4'b0100,
                 ev: 1'b0, ed: 8'h00, eid: 2'd0};
    end
    tbl[9]  = '{v: 4'b0100, d: 4'b0000, r: 1'b1, er: 4'b0000, ev: 1'b1, ed: 8'h4D, eid: 2'd2};
    tbl[10] = '{v: 4'b0100, d: 4'b0000, r: 1'b1, er: 4'b0000, ev: 1'b0, ed: 8'h00, eid: 2'd0};

    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    rst       = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    $display("[TB] directed single-source table");
    for (int i = 0; i < 11; i++) begin
      req_valid = tbl[i].v;
      req_data  = tbl[i].d;
      out_ready = tbl[i].r;
      checkOutput($sformatf("tbl%0d_req_ready", i), req_ready, tbl[i].er);
      checkOutput($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        checkOutput($sformatf("tbl%0d_out_data", i), out_data, tbl[i].ed);
        checkOutput($sformatf("tbl%0d_out_id", i), out_id, tbl[i].eid);
      end
      @(posedge clk);
      #1;
    end

    // Fairness: everyone valid, downstream always ready.
    $display("[TB] fairness");
    do_reset();
    nf = 0;
    exp_ids = '{0, 1, 2, 3, 0};
    for (int c = 0; c < 52; c++) begin
      checkOutput("rdy_onehot0", 64'($onehot0(req_ready)), 64'd1);
      if (out_valid && nf < 5) begin
        ids[nf] = int'(out_id);
        at[nf]  = c;
        nf++;
      end
      applyStimulus(4'hF, 4'($urandom), 1'b1);
    end
    checkOutput("fair_frames", nf, 5);
    for (int i = 0; i < 5; i++) begin
      if (i < nf) checkOutput($sformatf("fair_id%0d", i), ids[i], exp_ids[i]);
    end
    if (nf >= 1) checkOutput("fair_first_latency", at[0], 9);
    for (int i = 1; i < 5; i++) begin
      if (i < nf) checkOutput($sformatf("fair_period%0d", i), at[i] - at[i-1], W + 2);
    end

    // Gaps: requester 0 stalls for 5 cycles after bit 3 while requester 1
    // keeps asking; the grant must hold.
    $display("[TB] gaps");
    do_reset();
    pat = 8'hC3;
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    for (int b = 0; b < 3; b++) applyStimulus(4'b0011, {2'b00, ~pat[b], pat[b]}, 1'b1);
    for (int g = 0; g < 5; g++) begin
      checkOutput("gap_ready", req_ready, 4'b0001);
      applyStimulus(4'b0010, 4'b0010, 1'b1);
    end
    for (int b = 3; b < 8; b++) applyStimulus(4'b0011, {2'b00, ~pat[b], pat[b]}, 1'b1);
    checkOutput("gap_valid_at_14", out_valid, 1);
    checkOutput("gap_data", out_data, 8'hC3);
    checkOutput("gap_id", out_id, 0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("gap_single_pulse", out_valid, 0);

    // Back-pressure: downstream stalls 10 cycles, accepts on the 11th.
    $display("[TB] back-pressure");
    do_reset();
    pat = 8'h96;
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    for (int b = 0; b < 8; b++) applyStimulus(4'b0010, {2'b00, pat[b], 1'b0}, 1'b0);
    for (int s = 0; s < 10; s++) begin
      checkOutput("bp_valid", out_valid, 1);
      checkOutput("bp_data", out_data, 8'h96);
      checkOutput("bp_id", out_id, 1);
      checkOutput("bp_ready", req_ready, 0);
      applyStimulus(4'hF, 4'($urandom), 1'b0);
    end
    checkOutput("bp_valid_11", out_valid, 1);
    applyStimulus(4'hF, 4'($urandom), 1'b1);
    checkOutput("bp_after", out_valid, 0);
    checkOutput("bp_after_ready", req_ready, 0);

    // Reset mid-frame: requester 3 loses its partial frame.
    $display("[TB] reset mid-frame");
    do_reset();
    applyStimulus(4'b1000, 4'b0000, 1'b1);
    for (int b = 0; b < 4; b++) applyStimulus(4'b1000, 4'b1000, 1'b1);
    do_reset();
    pat = 8'h5A;
    applyStimulus(4'b1001, 4'b0000, 1'b1);
    for (int b = 0; b < 8; b++) begin
      checkOutput("rmf_no_valid", out_valid, 0);
      applyStimulus(4'b1001, {~pat[b], 2'b00, pat[b]}, 1'b1);
    end
    checkOutput("rmf_valid", out_valid, 1);
    checkOutput("rmf_data", out_data, 8'h5A);
    checkOutput("rmf_id", out_id, 0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);

    // Noise on requesters 1 and 3 while requester 0 owns the frame.
    $display("[TB] non-granted noise");
    do_reset();
    pat = 8'h3C;
    applyStimulus({1'($urandom), 1'b0, 1'($urandom), 1'b1}, 4'($urandom), 1'b1);
    for (int b = 0; b < 8; b++) begin
      applyStimulus({1'($urandom), 1'b0, 1'($urandom), 1'b1},
                    {3'($urandom), pat[b]}, 1'b1);
    end
    checkOutput("noise_valid", out_valid, 1);
    checkOutput("noise_data", out_data, 8'h3C);
    checkOutput("noise_id", out_id, 0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);

    // Randomized traffic against the reference model, with occasional resets.
    $display("[TB] random traffic");
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      applyStimulus(4'($urandom) | 4'($urandom), 4'($urandom),
                    1'($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_frame_arbiter.md
SERIAL_FRAME_ARBITER -- requirements
Module: serial_frame_arbiter

Interface
REQ-001 Parameter n_req, default 4, number of serial requesters; legal range 2..16.
REQ-002 Parameter width, default 8, bits per frame; legal range 2..64.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserted when 0, released synchronously to clk.
REQ-005 req_valid  input  n_req  per-requester serial bit valid.
REQ-006 req_data  input  n_req  per-requester serial data bit.
REQ-007 req_ready  output  n_req  per-requester bit accept; a bit transfers when req_valid[i] && req_ready[i].
REQ-008 out_valid  output  1  assembled frame available.
REQ-009 out_data  output  width  assembled frame.
REQ-010 out_id  output  $clog2(n_req)  index of the requester that sourced out_data.
REQ-011 out_ready  input  1  downstream accept; a frame transfers when out_valid && out_ready.

Function
REQ-012 The block SHALL share one shift-in deserializer among n_req serial sources, granting one source for a whole frame of exactly width bits.
REQ-013 The FSM SHALL have three states: IDLE, COLLECT, OUTPUT.
REQ-014 IDLE: req_ready all 0, out_valid 0; if any req_valid bit is 1, register grant = round-robin winner, clear bit counter, go to COLLECT next cycle; otherwise stay.
REQ-015 Round-robin: search starts at last_grant+1 modulo n_req, upward with wrap; first requester with req_valid=1 wins.
REQ-016 COLLECT: req_ready[grant]=1, all other req_ready bits 0; req_valid of non-granted requesters SHALL be ignored.
REQ-017 Each accepted bit SHALL be stored so the first accepted bit of a frame lands in out_data[0] and the width-th in out_data[width-1].
REQ-018 Cycles with req_valid[grant]=0 in COLLECT SHALL be gaps: no bit stored, counter unchanged, grant held; gaps of any length are legal.
REQ-019 On acceptance of the width-th bit, go to OUTPUT; out_valid SHALL be 1 in the next cycle; req_ready SHALL be 0 from that cycle on.
REQ-020 Latency: width bits with no gaps -> out_valid rises exactly width+1 cycles after the IDLE cycle that made the grant.
REQ-021 OUTPUT: out_valid=1; out_data and out_id SHALL remain stable until out_valid && out_ready.
REQ-022 On output handshake: last_grant <= grant, go to IDLE; out_valid=0 next cycle.
REQ-023 out_ready while out_valid=0 SHALL have no effect; out_ready held high yields exactly one out_valid cycle per frame.
REQ-024 Bit counter width: $clog2(width+1); counter SHALL never exceed width.
REQ-025 A requester dropping req_valid mid-frame SHALL NOT release the grant; a frame is never truncated or mixed across requesters.
REQ-026 Minimum frame period with no gaps and out_ready=1: width+2 cycles (IDLE, width COLLECT, OUTPUT).

Reset
REQ-027 While rst=0: state IDLE, req_ready=0, out_valid=0, out_data=0, out_id=0, counter=0, last_grant=n_req-1 (requester 0 has first priority).
REQ-028 Reset asserted mid-COLLECT or mid-OUTPUT SHALL discard the partial or pending frame with no out_valid pulse.
REQ-029 After release, the first grant SHALL follow REQ-015 from last_grant=n_req-1.

Verification (n_req=4, width=8)
REQ-030 Single source: req_valid[2]=1 continuously, bits 1,0,1,1,0,0,1,0 -> out_data=8'h4D, out_id=2, out_valid 9 cycles after grant cycle.
REQ-031 Fairness: all req_valid=1 from reset, out_ready=1 -> out_id sequence 0,1,2,3,0; req_ready one-hot or zero every cycle.
REQ-032 Gaps: granted source idles 5 cycles after bit 3 while requester 1 is valid -> grant held; frame correct; out_valid 14 cycles after grant cycle.
REQ-033 Back-pressure: out_ready=0 for 10 cycles after out_valid -> out_valid, out_data, out_id stable; req_ready all 0; handshake on cycle 11; IDLE next.
REQ-034 Reset mid-frame: rst=0 after 4 bits of requester 3, then release -> no out_valid; next frame from requester 0 if valid, with 8 fresh bits.
REQ-035 Non-granted noise: toggling req_valid/req_data on requesters 1,3 while 0 is granted -> out_data equals requester 0's bits, out_id=0.
